// File: rtl/mont_modexp_pkg.sv
// Shared definitions for the Montgomery modular-exponentiation block:
// FSM state encoding, width constants and the parameter legality check.
package mont_modexp_pkg;

    localparam int EXP_W_DEF = 16;
    localparam int DATA_W    = 16;
    localparam int PROD_W    = 32;
    localparam int NBITS_W   = 5;

    localparam logic [NBITS_W-1:0] N_MAX = 5'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_B,
        S_CONV_1,
        S_SQR,
        S_MUL,
        S_OUT,
        S_DONE,
        S_FAIL
    } state_e;

    // Odd modulus, 1 <= n <= N_MAX and m < 2^n.
    function automatic logic params_legal(
        input logic [DATA_W-1:0]  mod,
        input logic [NBITS_W-1:0] nb
    );
        logic ok;
        ok = mod[0];
        if (nb == '0)
            ok = 1'b0;
        if (nb > N_MAX)
            ok = 1'b0;
        if ((mod >> nb) != '0)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/mont_reduce.sv
// Combinational Montgomery reduction: r = x * 2^-n mod m, result < m.
// Ports: x_i product, m_i modulus, m_inv_i -m^-1 mod 2^n, n_i bits, r_o.
module mont_reduce
    import mont_modexp_pkg::*;
(
    input  logic [PROD_W-1:0]  x_i,
    input  logic [DATA_W-1:0]  m_i,
    input  logic [DATA_W-1:0]  m_inv_i,
    input  logic [NBITS_W-1:0] n_i,
    output logic [DATA_W-1:0]  r_o
);

    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] mu;
    logic [PROD_W-1:0] mu_m;
    logic [PROD_W-1:0] sum;
    logic [DATA_W:0]   t;
    logic [DATA_W:0]   t_sub;

    assign mask = ~({DATA_W{1'b1}} << n_i);

    // Only the low n bits of x matter for mu; a 16-bit product suffices
    // since n never exceeds 15.
    assign mu = (x_i[DATA_W-1:0] * m_inv_i) & mask;

    assign mu_m = {{(PROD_W-DATA_W){1'b0}}, mu}
                * {{(PROD_W-DATA_W){1'b0}}, m_i};

    // Legal operands keep this sum below 2^31, so no carry is lost.
    assign sum = x_i + mu_m;

    // Quotient is below 2m, which fits in DATA_W+1 bits.
    assign t = (DATA_W+1)'(sum >> n_i);

    assign t_sub = t - {1'b0, m_i};

    // Borrow out means t < m already.
    assign r_o = t_sub[DATA_W] ? t[DATA_W-1:0] : t_sub[DATA_W-1:0];

endmodule

// File: rtl/mont_modexp.sv
// Montgomery modular exponentiation controller: result = base^exp mod m,
// left-to-right square-and-multiply over all EXP_W exponent bits.
// Ports: clk, rst (async high), start; base, exp, m, m_inv, r2, n operands;
// busy, done (pulse), err (illegal parameters), result.
module mont_modexp
    import mont_modexp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  base,
    input  logic [EXP_W-1:0]   exp,
    input  logic [DATA_W-1:0]  m,
    input  logic [DATA_W-1:0]  m_inv,
    input  logic [DATA_W-1:0]  r2,
    input  logic [NBITS_W-1:0] n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(EXP_W - 1);

    state_e             state_q;
    logic [DATA_W-1:0]  base_q;
    logic [EXP_W-1:0]   exp_q;
    logic [DATA_W-1:0]  m_q;
    logic [DATA_W-1:0]  minv_q;
    logic [DATA_W-1:0]  r2_q;
    logic [NBITS_W-1:0] n_q;
    logic [DATA_W-1:0]  am_q;
    logic [DATA_W-1:0]  acc_q;
    logic [IW-1:0]      idx_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [DATA_W-1:0]  result_q;

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]  red;

    // Operand selection for the single reduction stage.
    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (state_q)
            S_CONV_B: begin
                op_a = base_q;
                op_b = r2_q;
            end
            S_CONV_1: begin
                op_a = r2_q;
                op_b = DATA_W'(1);
            end
            S_SQR: begin
                op_a = acc_q;
                op_b = acc_q;
            end
            S_MUL: begin
                op_a = acc_q;
                op_b = am_q;
            end
            S_OUT: begin
                op_a = acc_q;
                op_b = DATA_W'(1);
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    assign prod = {{(PROD_W-DATA_W){1'b0}}, op_a}
                * {{(PROD_W-DATA_W){1'b0}}, op_b};

    mont_reduce u_reduce (
        .x_i     (prod),
        .m_i     (m_q),
        .m_inv_i (minv_q),
        .n_i     (n_q),
        .r_o     (red)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            m_q      <= '0;
            minv_q   <= '0;
            r2_q     <= '0;
            n_q      <= '0;
            am_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        m_q    <= m;
                        minv_q <= m_inv;
                        r2_q   <= r2;
                        n_q    <= n;
                        if (params_legal(m, n)) begin
                            busy_q  <= 1'b1;
                            idx_q   <= IDX_TOP;
                            state_q <= S_CONV_B;
                        end else begin
                            // Report right away; result is kept.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_CONV_B: begin
                    am_q    <= red;
                    state_q <= S_CONV_1;
                end
                S_CONV_1: begin
                    acc_q   <= red;
                    state_q <= S_SQR;
                end
                S_SQR: begin
                    acc_q <= red;
                    if (exp_q[idx_q]) begin
                        state_q <= S_MUL;
                    end else if (idx_q == '0) begin
                        state_q <= S_OUT;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= S_SQR;
                    end
                end
                S_MUL: begin
                    acc_q <= red;
                    if (idx_q == '0) begin
                        state_q <= S_OUT;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= S_SQR;
                    end
                end
                S_OUT: begin
                    // Output flags land together with the result.
                    result_q <= red;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    err_q    <= 1'b0;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mont_modexp.sv
// Scoreboard bench for mont_modexp: directed cases plus a random sweep,
// expectations from a plain-arithmetic modular exponentiation model.
module tb_mont_modexp;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic [15:0] exp;
    logic [15:0] m;
    logic [15:0] m_inv;
    logic [15:0] r2;
    logic [4:0]  n;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;

    mont_modexp dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .exp    (exp),
        .m      (m),
        .m_inv  (m_inv),
        .r2     (r2),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    typedef struct {
        logic [15:0] res;
        logic        err;
        longint      due;
        int          busy_n;
    } exp_t;

    exp_t        sb[$];
    longint      cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_cnt;
    logic [15:0] last_res = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, want, $time);
        end
    endtask

    function automatic logic [15:0] ref_modexp(input logic [15:0] b,
                                               input logic [15:0] e,
                                               input logic [15:0] mm);
        longint r;
        longint md;
        md = longint'(mm);
        r  = 1 % md;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % md;
            if (e[i])
                r = (r * longint'(b)) % md;
        end
        return 16'(r);
    endfunction

    function automatic bit ref_legal(input logic [15:0] mm,
                                     input logic [4:0] nn);
        if (mm[0] == 1'b0) return 1'b0;
        if (nn == 0 || nn > 15) return 1'b0;
        if (longint'(mm) >= (longint'(1) << nn)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] calc_minv(input logic [15:0] mm,
                                              input logic [4:0] nn);
        logic [15:0] inv;
        logic [15:0] mask;
        inv = mm;
        repeat (4) inv = inv * (16'd2 - mm * inv);
        mask = 16'((32'd1 << nn) - 32'd1);
        return (16'd0 - inv) & mask;
    endfunction

    function automatic logic [15:0] calc_r2(input logic [15:0] mm,
                                            input logic [4:0] nn);
        return 16'((longint'(1) << (2 * nn)) % longint'(mm));
    endfunction

    // Called on a rising edge; start is high for exactly one cycle.
    task automatic issue(input logic [15:0] b, input logic [15:0] e,
                         input logic [15:0] mm, input logic [15:0] mi,
                         input logic [15:0] rr, input logic [4:0] nn);
        exp_t x;
        int   lat;
        #1;
        if (ref_legal(mm, nn)) begin
            x.res    = ref_modexp(b, e, mm);
            x.err    = 1'b0;
            lat      = 20 + $countones(e);
            x.busy_n = lat - 1;
            last_res = x.res;
        end else begin
            x.res    = last_res;
            x.err    = 1'b1;
            lat      = 1;
            x.busy_n = 0;
        end
        x.due = cyc + lat;
        sb.push_back(x);
        base  = b;
        exp   = e;
        m     = mm;
        m_inv = mi;
        r2    = rr;
        n     = nn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic legal_op(input logic [15:0] b, input logic [15:0] e,
                            input logic [15:0] mm, input logic [4:0] nn);
        issue(b, e, mm, calc_minv(mm, nn), calc_r2(mm, nn), nn);
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy)
                    busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_done: got 1, expected 0");
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("err", 64'(err), 64'(e.err));
                        check("done_cycle", 64'(cyc), 64'(e.due));
                        check("busy_cycles", 64'(busy_cnt),
                              64'(e.busy_n));
                        check("busy_at_done", 64'(busy), 64'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  nn;
        logic [15:0] mm;
        logic [15:0] bb;
        logic [15:0] ee;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        m     = '0;
        m_inv = '0;
        r2    = '0;
        n     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(posedge clk);

        issue(16'd4, 16'd13, 16'd13, 16'd11, 16'd9, 5'd4);
        drain();
        issue(16'd7, 16'd0, 16'd13, 16'd11, 16'd9, 5'd4);
        drain();
        issue(16'd0, 16'd5, 16'd13, 16'd11, 16'd9, 5'd4);
        drain();
        legal_op(16'd2, 16'd32748, 16'd32749, 5'd15);
        drain();

        issue(16'd5, 16'd3, 16'd12, 16'd1, 16'd1, 5'd4);
        drain();
        issue(16'd5, 16'd3, 16'd13, 16'd11, 16'd9, 5'd0);
        drain();
        issue(16'd5, 16'd3, 16'd20, 16'd1, 16'd1, 5'd4);
        drain();
        issue(16'd5, 16'd3, 16'd17, 16'd1, 16'd1, 5'd4);
        drain();
        issue(16'd5, 16'd3, 16'd13, 16'd11, 16'd9, 5'd16);
        drain();

        issue(16'd4, 16'd13, 16'd13, 16'd11, 16'd9, 5'd4);
        repeat (5) @(posedge clk);
        #1;
        base  = 16'd3;
        exp   = 16'hFFFF;
        m     = 16'd11;
        m_inv = calc_minv(16'd11, 5'd4);
        r2    = calc_r2(16'd11, 5'd4);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        legal_op(16'd3, 16'hBEEF, 16'd32749, 5'd15);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        sb.delete();
        last_res = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        legal_op(16'd5, 16'd1234, 16'd1009, 5'd10);
        drain();

        for (int v = 0; v < 500; v++) begin
            nn = 5'($urandom_range(1, 15));
            mm = 16'($urandom_range(0, (1 << nn) - 1)) | 16'd1;
            bb = 16'($urandom % 32'(mm));
            ee = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                mm = mm + 16'd1;
                issue(bb, ee, mm, calc_minv(mm | 16'd1, nn),
                      16'd0, nn);
            end else begin
                legal_op(bb, ee, mm, nn);
            end
            drain();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
